// File: rtl/logic_op_pkg.sv
// Shared types for the gate-lab sequencer: operation and state encodings,
// the registered controller state, and the gate evaluator.
package logic_op_pkg;

    localparam int N_OPS = 6;

    typedef enum logic [2:0] {
        AND  = 3'd0,
        OR   = 3'd1,
        XOR  = 3'd2,
        NAND = 3'd3,
        NOR  = 3'd4,
        XNOR = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        AUTO  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // Everything the controller sequences, kept together so it can be probed as one unit.
    typedef struct packed {
        state_t     state;
        op_t        op;
        logic [1:0] combo;
    } sched_state_t;

    function automatic logic apply_op(op_t op, logic a, logic b);
        case (op)
            AND:     apply_op = a & b;
            OR:      apply_op = a | b;
            XOR:     apply_op = a ^ b;
            NAND:    apply_op = ~(a & b);
            NOR:     apply_op = ~(a | b);
            XNOR:    apply_op = ~(a ^ b);
            default: apply_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/key_press_detect.sv
// One key: 2-flop synchronizer, stability counter and rising-edge pulse on the
// accepted level.
module key_press_detect #(
    parameter int unsigned debounce_cycles = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    localparam int unsigned CW = (debounce_cycles > 1) ? $clog2(debounce_cycles) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(debounce_cycles - 1);

    logic          sync1;
    logic          sync2;
    logic          stable_q;
    logic          stable_d;
    logic          press_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable_q <= 1'b0;
            stable_d <= 1'b0;
            press_q  <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= key;
            sync2    <= sync1;
            stable_d <= stable_q;
            press_q  <= stable_q & ~stable_d;
            // Any sample equal to the accepted level restarts the run of differing samples.
            if (sync2 == stable_q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable_q <= sync2;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/logic_op_scheduler.sv
// Steps the shared gate evaluator through six ops x four input combos, either on
// a timer (AUTO) or one key press at a time (PAUSE), and shows it on the LEDs.
module logic_op_scheduler
    import logic_op_pkg::*;
#(
    parameter int unsigned clk_mhz         = 50,
    parameter int unsigned w_key           = 4,
    parameter int unsigned w_led           = 8,
    parameter int unsigned step_cycles     = 25_000_000,
    parameter int unsigned debounce_cycles = 500_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [w_key-1:0] key,
    output logic [w_led-1:0] led,
    output logic [2:0]       op,
    output logic             sweep_done
);

    localparam int unsigned TW = (step_cycles > 2) ? $clog2(step_cycles) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(step_cycles - 1);
    localparam op_t OP_LAST = op_t'(3'(N_OPS - 1));

    if (clk_mhz == 0 || w_key < 4 || w_led < 7 || step_cycles < 2) begin : g_param_check
        $error("logic_op_scheduler: unsupported parameter combination");
    end

    logic [w_key-1:0] press;

    for (genvar i = 0; i < int'(w_key); i++) begin : g_key
        key_press_detect #(
            .debounce_cycles(debounce_cycles)
        ) u_kpd (
            .clk  (clk),
            .rst  (rst),
            .key  (key[i]),
            .press(press[i])
        );
    end

    sched_state_t     cur;
    sched_state_t     nxt;
    logic [TW-1:0]    timer_q;
    logic [TW-1:0]    timer_d;
    logic [w_led-1:0] led_q;
    logic [w_led-1:0] led_d;
    logic             sweep_q;
    logic             sweep_d;
    logic             act_idle;
    logic             act_clear;
    logic             act_toggle;
    logic             act_single;
    logic             step;
    logic             wrap;
    logic             result;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= '{state: IDLE, op: AND, combo: 2'b00};
            timer_q <= '0;
            led_q   <= '0;
            sweep_q <= 1'b0;
        end else begin
            cur     <= nxt;
            timer_q <= timer_d;
            led_q   <= led_d;
            sweep_q <= sweep_d;
        end
    end

    // Next-state: key priority 3 > 2 > 0 > 1, only one action per cycle.
    always_comb begin
        nxt        = cur;
        timer_d    = '0;
        act_idle   = press[3];
        act_clear  = ~press[3] & press[2];
        act_toggle = ~press[3] & ~press[2] & press[0];
        act_single = ~press[3] & ~press[2] & ~press[0] & press[1] & (cur.state == PAUSE);
        step       = act_single |
                     ((cur.state == AUTO) && (timer_q == TIMER_LAST) &&
                      !act_idle && !act_clear && !act_toggle);
        wrap       = 1'b0;

        if (act_idle) begin
            nxt.state = IDLE;
        end else if (act_toggle) begin
            case (cur.state)
                IDLE:    nxt.state = AUTO;
                AUTO:    nxt.state = PAUSE;
                PAUSE:   nxt.state = AUTO;
                default: nxt.state = IDLE;
            endcase
        end

        if (act_idle || act_clear || nxt.state == IDLE) begin
            nxt.op    = AND;
            nxt.combo = 2'b00;
        end else if (step) begin
            nxt.combo = cur.combo + 2'd1;
            if (cur.combo == 2'b11) begin
                if (cur.op == OP_LAST) begin
                    nxt.op = AND;
                    wrap   = 1'b1;
                end else begin
                    nxt.op = op_t'(cur.op + 3'd1);
                end
            end
        end

        // Timer restarts on AUTO entry and on every step; it only runs in AUTO.
        if (nxt.state == AUTO && cur.state == AUTO && !step && timer_q != TIMER_LAST) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Outputs are computed from the next state so a, b, result and op land together.
    always_comb begin
        result  = apply_op(nxt.op, nxt.combo[1], nxt.combo[0]);
        led_d   = '0;
        sweep_d = wrap;
        if (nxt.state != IDLE) begin
            led_d[0]   = nxt.combo[1];
            led_d[1]   = nxt.combo[0];
            led_d[2]   = result;
            led_d[3]   = (nxt.state == AUTO);
            led_d[6:4] = nxt.op;
        end
    end

    assign led        = led_q;
    assign op         = cur.op;
    assign sweep_done = sweep_q;

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Directed bench for logic_op_scheduler with short step and debounce intervals.
module tb_logic_op_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key;
    logic [7:0] led;
    logic [2:0] op;
    logic       sweep_done;

    int n_asserts = 0;
    int n_fails   = 0;
    int sdone_cnt = 0;

    logic [7:0] prev_led;
    logic [7:0] exp_v;

    logic_op_scheduler #(
        .clk_mhz        (50),
        .w_key          (4),
        .w_led          (8),
        .step_cycles    (4),
        .debounce_cycles(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .led       (led),
        .op        (op),
        .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sweep_done === 1'b1) sdone_cnt++;
    end

    task automatic step_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected LED word built from truth tables indexed by {a,b}.
    function automatic logic [7:0] exp_led(input int op_i, input int cmb, input bit auto_on);
        logic [3:0] tt;
        logic [1:0] c;
        logic [2:0] o;
        c = 2'(cmb);
        o = 3'(op_i);
        case (op_i)
            0:       tt = 4'b1000;
            1:       tt = 4'b1110;
            2:       tt = 4'b0110;
            3:       tt = 4'b0111;
            4:       tt = 4'b0001;
            default: tt = 4'b1001;
        endcase
        return {1'b0, o, auto_on, tt[c], c[0], c[1]};
    endfunction

    initial begin
        rst = 1'b1;
        key = 4'b0000;
        step_clk(3);
        rst = 1'b0;
        chk("reset_led", 32'(led), 32'h00);
        chk("reset_op", 32'(op), 32'h0);
        chk("reset_sweep", 32'(sweep_done), 32'h0);
        for (int i = 0; i < 20; i++) begin
            step_clk(1);
            chk("idle_led", 32'(led), 32'h00);
            chk("idle_op", 32'(op), 32'h0);
            chk("idle_sweep", 32'(sweep_done), 32'h0);
        end

        // Clean key[0] edge: press after 6 edges, AUTO visible after the 7th.
        key[0] = 1'b1;
        step_clk(6);
        chk("press_latency_before", 32'(led), 32'h00);
        step_clk(1);
        key[0] = 1'b0;
        chk("auto_entry_led", 32'(led), 32'h08);
        chk("auto_entry_op", 32'(op), 32'h0);

        // Full sweep of 24 timer steps.
        prev_led = 8'h08;
        for (int s = 1; s <= 24; s++) begin
            step_clk(3);
            chk("auto_hold", 32'(led), 32'(prev_led));
            step_clk(1);
            exp_v = exp_led((s / 4) % 6, s % 4, 1'b1);
            chk("auto_step_led", 32'(led), 32'(exp_v));
            chk("auto_step_op", 32'(op), 32'((s / 4) % 6));
            chk("auto_sweep_done", 32'(sweep_done), 32'(s == 24));
            prev_led = exp_v;
        end
        step_clk(1);
        chk("sweep_done_width", 32'(sweep_done), 32'h0);
        chk("sweep_done_count", 32'(sdone_cnt), 32'd1);

        // Pause just after the ninth step of the second sweep (op 2, combo 01).
        step_clk(29);
        key[0] = 1'b1;
        step_clk(7);
        key[0] = 1'b0;
        prev_led = exp_led(2, 1, 1'b0);
        chk("pause_led", 32'(led), 32'(prev_led));
        chk("pause_op", 32'(op), 32'h2);
        step_clk(10);
        chk("pause_hold_led", 32'(led), 32'(prev_led));
        chk("pause_sweep_count", 32'(sdone_cnt), 32'd1);

        // Three single steps: op2/10, op2/11, op3/00.
        for (int p = 1; p <= 3; p++) begin
            key[1] = 1'b1;
            step_clk(6);
            chk("single_before", 32'(led), 32'(prev_led));
            step_clk(1);
            key[1] = 1'b0;
            exp_v = exp_led((p == 3) ? 3 : 2, (p + 1) % 4, 1'b0);
            chk("single_step_led", 32'(led), 32'(exp_v));
            prev_led = exp_v;
            step_clk(8);
            chk("single_no_extra", 32'(led), 32'(prev_led));
        end
        chk("single_final_op", 32'(op), 32'h3);
        chk("single_final_result", 32'(led[2]), 32'h1);

        // Bounce shorter than the debounce interval must not step.
        for (int i = 0; i < 10; i++) begin
            key[1] = ((i % 4) < 2);
            step_clk(1);
        end
        key[1] = 1'b0;
        step_clk(10);
        chk("bounce_no_step", 32'(led), 32'(prev_led));

        // key[3] and key[0] pressed together: key[3] wins.
        key = 4'b1001;
        step_clk(7);
        key = 4'b0000;
        chk("simul_idle_led", 32'(led), 32'h00);
        chk("simul_idle_op", 32'(op), 32'h0);
        step_clk(8);
        chk("simul_idle_stays", 32'(led), 32'h00);

        // Back to AUTO, run to op 4, then reset.
        key[0] = 1'b1;
        step_clk(7);
        key[0] = 1'b0;
        chk("reauto_led", 32'(led), 32'h08);
        step_clk(66);
        chk("reauto_op4", 32'(op), 32'h4);
        chk("reauto_op4_led", 32'(led), 32'(exp_led(4, 0, 1'b1)));
        rst = 1'b1;
        step_clk(1);
        chk("midrst_led", 32'(led), 32'h00);
        chk("midrst_op", 32'(op), 32'h0);
        chk("midrst_sweep", 32'(sweep_done), 32'h0);
        rst = 1'b0;
        step_clk(10);
        chk("postrst_led", 32'(led), 32'h00);
        chk("final_sweep_count", 32'(sdone_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/logic_op_scheduler.md
# logic_op_scheduler

Sequencer for the two-input gate lab datapath. It steps a shared gate evaluator through six logic operations and all four input combinations, so the whole truth table plays out on the LEDs. Runs automatically on a timer or single-steps on key presses. Sits inside `lab_top`, driven by `key`, and drives `led`.

## Interface
- `clk_mhz`, 50, board clock in MHz (documentation only; timing uses the cycle parameters below)
- `w_key`, 4, key width; at least 4 keys are used
- `w_led`, 8, LED width; must be at least 7, and bits above 6 are driven 0
- `step_cycles`, 25_000_000, clock cycles per automatic step; must be at least 2
- `debounce_cycles`, 500_000, cycles a synchronized key level must stay stable before it is accepted

- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `key`  in  w_key  raw, asynchronous, active-high key levels
- `led`  out  w_led  registered: [0]=a, [1]=b, [2]=result, [3]=auto running, [6:4]=op index
- `op`  out  3  registered op index, 0..5
- `sweep_done`  out  1  one-cycle pulse on op 5→0 wrap

## Operation
- Ops by index: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR.
- Combo counter ab steps 00→01→10→11; a is combo[1], b is combo[0].
- A step increments combo.
  - On 11→00, op also increments.
  - On op 5 with combo 11, both go to 0 and `sweep_done` pulses.
- result = op(a,b). It is computed from the next-state op and combo and registered with them, so led[2:0] and led[6:4] are always mutually consistent.
- Every key passes through a key_press_detect instance, which produces a one-cycle `press` pulse.
- States:
  - IDLE: all LEDs 0, counters held at 0.
  - AUTO: step when the timer reaches step_cycles-1.
  - PAUSE: outputs held; key[1] press performs one step.
- Transitions:
  - key[0] press: IDLE→AUTO, AUTO→PAUSE, PAUSE→AUTO.
  - key[2] press: clears op and combo to 0, state unchanged, no `sweep_done`.
  - key[3] press: any state→IDLE, counters cleared.
- Simultaneous presses in the same cycle: priority key[3] > key[2] > key[0] > key[1]. Only the highest-priority action is taken.
- key[1] outside PAUSE is ignored.
- The step timer is cleared on every entry to AUTO and on every step. It does not count in IDLE or PAUSE.
- LED outputs in each state:
  - IDLE: led = 0.
  - AUTO and PAUSE: led shows the current a, b, result, op.
  - led[3] = 1 only in AUTO.
- Reset values: state IDLE, op 0, combo 00, timer 0, led 0, `sweep_done` 0, debouncer counters 0, stable levels 0.
- Reset mid-operation abandons the sweep. No `sweep_done` is issued.

## Timing
- Key path: 2-flop synchronizer, then a stability counter.
  - The level is accepted after debounce_cycles consecutive equal synchronized samples.
  - `press` asserts the cycle after the accepted level goes 0→1.
  - Latency from raw edge to `press` is debounce_cycles+3 cycles for a clean edge. Release produces no pulse.
  - A bounce shorter than debounce_cycles restarts the count and produces no pulse.
- The controller acts on `press` in the same cycle. Registered outputs change on the following edge.
- In AUTO, steps occur every step_cycles cycles. The first step comes step_cycles cycles after entering AUTO.
- `sweep_done` is high for exactly the cycle in which op/combo show 0/00 after a wrap.
- A full sweep is 24 steps.

## Structure
- Package logic_op_pkg holds:
  - enum op_t: AND..XNOR, 3 bits.
  - enum state_t: IDLE, AUTO, PAUSE.
  - localparam N_OPS = 6.
  - function apply_op(op_t, a, b).
- Sub-module key_press_detect: synchronizer, debounce counter and rise detector for one key, with parameter debounce_cycles. Instantiate 4 times via generate.
- Top: FSM, step timer, op/combo counters, output register.

## Test plan
Bench uses step_cycles=4 and debounce_cycles=3.
- Reset, then 20 idle cycles → led=0, op=0, `sweep_done`=0 throughout.
- Clean key[0] press → `press` arrives 6 cycles after the edge; led[3]=1. Steps every 4 cycles: led[1:0] goes 00,10,01,11 (bit0=a). op=0, and led[2] goes 0,0,0,1.
- Run AUTO for 24 steps → op visits 0..5 in order; `sweep_done` pulses once, exactly 96 cycles after AUTO entry; op=0 and combo=00 in that cycle. Check result against all 24 truth-table entries.
- Pause with key[0], then press key[1] three times → exactly three steps; no timer steps in between. From op 2, combo 01, expect combo 00 of op 3 with result 1.
- Bounce key[1] with 2-cycle pulses for 10 cycles → no step. Press key[3] and key[0] so their `press` pulses land in the same cycle → IDLE, led=0.
- Assert `rst` during AUTO at op 4 → next cycle led=0, op=0; no `sweep_done`.
